ca_seed_gen: RTL and testbench

CA_SEED_GEN -- requirements
Module: ca_seed_gen

---
 rtl/ca_pkg.sv | 32 +++
 rtl/ca_lfsr16.sv | 43 ++++
 rtl/ca_seed_gen.sv | 130 +++++++++++++
 tb/tb_ca_seed_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: shared constants, enums and LFSR helper for the cellular-automaton
// seed generator.
//   CELLS / CENTER        : default row length and single-cell index
//   LFSR_SEED / LFSR_TAPS : 16-bit Galois LFSR reload value and tap mask
//   seed_mode_e           : seed source selection
//   state_e               : row FSM states
package ca_pkg;

  localparam int          CELLS     = 320;
  localparam int          CENTER    = 160;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SEED_SINGLE      = 2'd0,
    SEED_PATTERN     = 2'd1,
    SEED_LFSR        = 2'd2,
    SEED_LFSR_FROZEN = 2'd3
  } seed_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Right-shifting Galois step: taps are folded in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ca_lfsr16.sv
// ca_lfsr16: 16-bit right-shifting Galois LFSR.
//   clk   : pixel clock
//   reset : synchronous active-high, reloads LFSR_SEED
//   load  : reload LFSR_SEED (wins over step)
//   step  : advance one position
//   state : current LFSR contents
module ca_lfsr16
  import ca_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_d;
  logic [15:0] state_q;

  // Next-state selection: reload, advance or hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = LFSR_SEED;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ca_seed_gen.sv
// ca_seed_gen: produces one seed row for a cellular automaton, one bit per
// accepted request, starting at each frame_start.
//   clk, reset         : pixel clock, synchronous active-high reset
//   frame_start        : restart row at cell 0, latch mode/pattern
//   cell_req           : consumer takes the current bit this cycle
//   mode, pattern      : seed source and 8-bit repeating pattern
//   seed_bit           : seed value of the current cell
//   seed_valid         : high while a row is being delivered
//   row_done           : one-cycle pulse after the last cell is taken
module ca_seed_gen
  import ca_pkg::*;
#(
  parameter int CELLS  = ca_pkg::CELLS,
  parameter int CENTER = ca_pkg::CENTER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       cell_req,
  input  logic [1:0] mode,
  input  logic [7:0] pattern,
  output logic       seed_bit,
  output logic       seed_valid,
  output logic       row_done
);

  // +1 keeps the width non-zero for tiny rows while still covering CELLS-1.
  localparam int                CNT_W    = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CELLS - 1);
  localparam logic [CNT_W-1:0] CENTER_C = CNT_W'(CENTER);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  seed_mode_e       mode_d, mode_q;
  logic [7:0]       pat_d, pat_q;
  logic             valid_d, valid_q;
  logic             row_done_d, row_done_q;
  logic             lfsr_load_s;
  logic             lfsr_step_s;
  logic [15:0]      lfsr_state_s;
  logic             seed_bit_s;

  // FSM next state, counter, latched configuration and LFSR control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    row_done_d  = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    if (frame_start) begin
      // A coincident cell_req is deliberately dropped here.
      state_d     = ST_ROW;
      cnt_d       = '0;
      mode_d      = seed_mode_e'(mode);
      pat_d       = pattern;
      lfsr_load_s = (seed_mode_e'(mode) == SEED_LFSR_FROZEN);
    end else begin
      case (state_q)
        ST_ROW: begin
          if (cell_req) begin
            lfsr_step_s = (mode_q == SEED_LFSR) || (mode_q == SEED_LFSR_FROZEN);
            if (cnt_q == LAST_C) begin
              // Counter parks on the last cell instead of wrapping.
              state_d    = ST_DONE;
              row_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = ST_ROW;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    valid_d = (state_d == ST_ROW);
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= SEED_SINGLE;
      pat_q      <= 8'h00;
      valid_q    <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      valid_q    <= valid_d;
      row_done_q <= row_done_d;
    end
  end

  ca_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .state (lfsr_state_s)
  );

  // Seed bit decode from registered state; forced low outside a row.
  always_comb begin
    seed_bit_s = 1'b0;
    if (valid_q) begin
      case (mode_q)
        SEED_SINGLE:      seed_bit_s = (cnt_q == CENTER_C);
        SEED_PATTERN:     seed_bit_s = pat_q[3'(cnt_q)];
        SEED_LFSR:        seed_bit_s = lfsr_state_s[0];
        SEED_LFSR_FROZEN: seed_bit_s = lfsr_state_s[0];
        default:          seed_bit_s = 1'b0;
      endcase
    end else begin
      seed_bit_s = 1'b0;
    end
  end

  assign seed_bit   = seed_bit_s;
  assign seed_valid = valid_q;
  assign row_done   = row_done_q;

endmodule

// File: tb/tb_ca_seed_gen.sv
// Scoreboard bench for ca_seed_gen: stimulus pushes expected seed bits, a
// monitor thread pops one per accepted cell and compares.
module tb_ca_seed_gen;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic       cell_req;
  logic [1:0] mode;
  logic [7:0] pattern;
  logic       seed_bit;
  logic       seed_valid;
  logic       row_done;

  int n_cmp;
  int n_err;
  bit exp_q[$];

  ca_seed_gen dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .cell_req    (cell_req),
    .mode        (mode),
    .pattern     (pattern),
    .seed_bit    (seed_bit),
    .seed_valid  (seed_valid),
    .row_done    (row_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push n expected bits, written left-to-right in v (first bit is MSB).
  task automatic push_vec(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[n-1-i]);
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [7:0] p);
    mode        = m;
    pattern     = p;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic accept(input int n);
    cell_req = 1'b1;
    step(n);
    cell_req = 1'b0;
  endtask

  task automatic monitor();
    bit e;
    forever begin
      @(negedge clk);
      if (!seed_valid && seed_bit) chk("bit_low_when_invalid", {31'd0, seed_bit}, 32'd0);
      if (seed_valid && cell_req && !frame_start && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("seed_bit", {31'd0, seed_bit}, {31'd0, e});
        end
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    frame_start = 1'b1;
    cell_req    = 1'b0;
    mode        = 2'd0;
    pattern     = 8'h00;
    fork
      monitor();
    join_none

    // Reset wins over a simultaneous frame_start.
    step(2);
    chk("rst_valid", {31'd0, seed_valid}, 32'd0);
    chk("rst_bit", {31'd0, seed_bit}, 32'd0);
    chk("rst_row_done", {31'd0, row_done}, 32'd0);
    reset       = 1'b0;
    frame_start = 1'b0;
    cell_req    = 1'b1;
    step(2);
    chk("idle_valid", {31'd0, seed_valid}, 32'd0);
    cell_req = 1'b0;

    // Mode 0: single cell at 160 over a full 320-cell row.
    start_frame(2'd0, 8'hFF);
    for (int i = 0; i < 320; i++) exp_q.push_back(i == 160);
    cell_req = 1'b1;
    for (int i = 0; i < 320; i++) begin
      step(1);
      if (i == 318) begin
        chk("m0_no_early_done", {31'd0, row_done}, 32'd0);
        chk("m0_valid_last", {31'd0, seed_valid}, 32'd1);
      end
    end
    chk("m0_row_done", {31'd0, row_done}, 32'd1);
    chk("m0_valid_after", {31'd0, seed_valid}, 32'd0);
    step(1);
    chk("m0_row_done_pulse", {31'd0, row_done}, 32'd0);
    chk("m0_valid_idle", {31'd0, seed_valid}, 32'd0);
    step(2);
    chk("m0_idle_ignores_req", {31'd0, seed_valid}, 32'd0);
    cell_req = 1'b0;

    // Mode 1: pattern LSB first, two periods.
    start_frame(2'd1, 8'b1000_0101);
    push_vec(32'b1010_0001_1010_0001, 16);
    accept(16);

    // Mode 3: identical bits in consecutive frames.
    start_frame(2'd3, 8'h00);
    push_vec(32'b100001, 6);
    accept(6);
    start_frame(2'd3, 8'h00);
    push_vec(32'b100001, 6);
    accept(6);

    // Mode 2: reload via a frozen frame, then persist across frames.
    start_frame(2'd3, 8'h00);
    start_frame(2'd2, 8'h00);
    push_vec(32'b100, 3);
    accept(3);
    start_frame(2'd2, 8'h00);
    push_vec(32'b001, 3);
    accept(3);

    // Toggled cell_req and mid-row mode/pattern change.
    start_frame(2'd1, 8'b1000_0101);
    push_vec(32'b1010, 4);
    cell_req = 1'b1; step(1);
    cell_req = 1'b0; step(1);
    cell_req = 1'b1; step(1);
    cell_req = 1'b0;
    mode     = 2'd0;
    pattern  = 8'h00;
    step(1);
    accept(2);
    chk("toggle_no_done", {31'd0, row_done}, 32'd0);

    // frame_start together with cell_req at cell 100.
    start_frame(2'd1, 8'b0000_0001);
    for (int i = 0; i < 100; i++) exp_q.push_back((i % 8) == 0);
    accept(100);
    cell_req    = 1'b1;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("restart_no_done", {31'd0, row_done}, 32'd0);
    push_vec(32'b1_0000_0001, 9);
    step(9);
    cell_req = 1'b0;
    chk("restart_still_row", {31'd0, seed_valid}, 32'd1);
    chk("restart_no_done2", {31'd0, row_done}, 32'd0);

    // Reset at cell 50 aborts the row and reloads the LFSR.
    start_frame(2'd1, 8'b1000_0101);
    for (int i = 0; i < 50; i++) exp_q.push_back(i % 8 == 0 || i % 8 == 2 || i % 8 == 7);
    accept(50);
    reset       = 1'b1;
    frame_start = 1'b1;
    step(1);
    chk("mid_rst_valid", {31'd0, seed_valid}, 32'd0);
    chk("mid_rst_bit", {31'd0, seed_bit}, 32'd0);
    chk("mid_rst_row_done", {31'd0, row_done}, 32'd0);
    reset       = 1'b0;
    frame_start = 1'b0;
    step(1);
    chk("post_rst_row_done", {31'd0, row_done}, 32'd0);
    chk("post_rst_valid", {31'd0, seed_valid}, 32'd0);
    start_frame(2'd2, 8'h00);
    push_vec(32'b100001, 6);
    accept(6);

    step(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
